// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC/IM fetch sequencer with IF output stage, stall, redirect and halt
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] im_addr,
    input  logic [31:0] im_instr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        halt,
    output logic        align_err,
    output logic [15:0] fetch_count
);

    localparam logic [31:0] PC_LIMIT = 32'(IM_WORDS * 4);

    typedef enum logic [1:0] {
        WARM = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic        if_valid_n, halt_n, align_err_n;
    logic [31:0] if_instr_n, if_pc_n, if_pc_plus4_n;
    logic [15:0] fetch_count_n;
    logic [31:0] target_pc;

    assign im_addr   = pc;
    assign target_pc = redirect_pc & ~32'd3;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WARM;
            pc          <= RESET_PC;
            if_valid    <= 1'b0;
            if_instr    <= 32'h0;
            if_pc       <= 32'h0;
            if_pc_plus4 <= 32'd4;
            halt        <= 1'b0;
            align_err   <= 1'b0;
            fetch_count <= 16'h0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            if_valid    <= if_valid_n;
            if_instr    <= if_instr_n;
            if_pc       <= if_pc_n;
            if_pc_plus4 <= if_pc_plus4_n;
            halt        <= halt_n;
            align_err   <= align_err_n;
            fetch_count <= fetch_count_n;
        end
    end

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        if_valid_n    = if_valid;
        if_instr_n    = if_instr;
        if_pc_n       = if_pc;
        if_pc_plus4_n = if_pc_plus4;
        halt_n        = halt;
        align_err_n   = 1'b0;
        fetch_count_n = fetch_count;

        case (state)
            WARM: begin
                state_n = RUN;
                if (redirect) begin
                    pc_n        = target_pc;
                    align_err_n = |redirect_pc[1:0];
                end
            end
            RUN: begin
                if (redirect) begin
                    // Bubble squashes the wrong-path word already fetched
                    pc_n        = target_pc;
                    if_valid_n  = 1'b0;
                    if_instr_n  = 32'h0;
                    align_err_n = |redirect_pc[1:0];
                end else if (stall) begin
                    state_n = RUN;
                end else if (pc >= PC_LIMIT) begin
                    if_valid_n = 1'b0;
                    if_instr_n = 32'h0;
                    halt_n     = 1'b1;
                    state_n    = HALT;
                end else begin
                    if_instr_n    = im_instr;
                    if_pc_n       = pc;
                    if_pc_plus4_n = pc + 32'd4;
                    if_valid_n    = 1'b1;
                    pc_n          = pc + 32'd4;
                    fetch_count_n = fetch_count + 16'd1;
                end
            end
            HALT: begin
                if_valid_n = 1'b0;
                halt_n     = 1'b1;
                if (redirect) begin
                    pc_n        = target_pc;
                    halt_n      = 1'b0;
                    align_err_n = |redirect_pc[1:0];
                    state_n     = RUN;
                end
            end
            default: begin
                state_n = WARM;
            end
        endcase
    end

endmodule
